// File: rtl/led_matrix_scanner.sv
// Time-multiplexed LED matrix row scanner with double-buffered frame storage.
// Handshake: load is a one-cycle strobe with no ready; frame_in is captured on every edge where load=1.
module led_matrix_scanner #(
    parameter int ROWS           = 7,
    parameter int COLS           = 5,
    parameter int DIV            = 1000,
    parameter int BLANK          = 2,
    parameter bit ROW_ACTIVE_LOW = 1'b0,
    parameter bit COL_ACTIVE_LOW = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     load,
    input  logic [ROWS*COLS-1:0]     frame_in,
    output logic [ROWS-1:0]          row_sel,
    output logic [COLS-1:0]          col_out,
    output logic [$clog2(ROWS)-1:0]  row_idx,
    output logic                     frame_done,
    output logic [1:0]               dbg_state
);

    localparam int RW   = $clog2(ROWS);
    localparam int TMAX = (DIV > BLANK) ? DIV : BLANK;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] T_DIV_END   = TW'(DIV - 1);
    localparam logic [TW-1:0] T_BLANK_END = TW'(BLANK - 1);
    localparam logic [RW-1:0] ROW_LAST    = RW'(ROWS - 1);

    // Encoding is visible on dbg_state: 0 = IDLE, 1 = BLANK, 2 = SHOW.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_SHOW  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [TW-1:0]          r_timer;
    logic [TW-1:0]          w_timer_nxt;
    logic [RW-1:0]          r_row;
    logic [RW-1:0]          w_row_nxt;
    logic                   w_boundary;
    logic [ROWS*COLS-1:0]   r_pending;
    logic [ROWS*COLS-1:0]   r_display;
    logic                   r_pending_valid;
    logic                   r_frame_done;
    logic                   w_lit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_row   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_row   <= w_row_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_row_nxt   = r_row;
        w_boundary  = 1'b0;
        if (!en) begin
            w_state_nxt = S_IDLE;
            w_timer_nxt = '0;
            w_row_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_BLANK;
                    w_timer_nxt = '0;
                end
                S_BLANK: begin
                    if (r_timer == T_BLANK_END) begin
                        w_state_nxt = S_SHOW;
                        w_timer_nxt = '0;
                    end else begin
                        w_timer_nxt = r_timer + 1'b1;
                    end
                end
                S_SHOW: begin
                    if (r_timer == T_DIV_END) begin
                        w_state_nxt = S_BLANK;
                        w_timer_nxt = '0;
                        if (r_row == ROW_LAST) begin
                            w_row_nxt  = '0;
                            w_boundary = 1'b1;
                        end else begin
                            w_row_nxt = r_row + 1'b1;
                        end
                    end else begin
                        w_timer_nxt = r_timer + 1'b1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // A load coinciding with the frame boundary bypasses pending so the newest frame wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending       <= '0;
            r_display       <= '0;
            r_pending_valid <= 1'b0;
            r_frame_done    <= 1'b0;
        end else begin
            r_frame_done <= w_boundary;
            if (load) begin
                r_pending       <= frame_in;
                r_pending_valid <= 1'b1;
            end
            if (w_boundary) begin
                if (load) begin
                    r_display       <= frame_in;
                    r_pending_valid <= 1'b0;
                end else if (r_pending_valid) begin
                    r_display       <= r_pending;
                    r_pending_valid <= 1'b0;
                end
            end else if (r_state == S_IDLE && load) begin
                r_display <= frame_in;
            end
        end
    end

    assign w_lit = (r_state == S_SHOW);

    always_comb begin
        row_sel = {ROWS{ROW_ACTIVE_LOW}};
        col_out = {COLS{COL_ACTIVE_LOW}};
        if (w_lit) begin
            row_sel = (ROWS'(1) << r_row) ^ {ROWS{ROW_ACTIVE_LOW}};
            col_out = r_display[r_row*COLS +: COLS] ^ {COLS{COL_ACTIVE_LOW}};
        end
    end

    assign row_idx    = r_row;
    assign frame_done = r_frame_done;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Bench for led_matrix_scanner: active-high and active-low instances share stimulus and a
// reference model that derives outputs from elapsed scan time.
module tb_led_matrix_scanner;

    localparam int ROWS  = 3;
    localparam int COLS  = 4;
    localparam int DIV   = 4;
    localparam int BLANK = 1;
    localparam int PER   = BLANK + DIV;
    localparam int FRAME = ROWS * PER;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [11:0] frame_in = '0;

    logic [2:0]  row_sel, row_sel_n;
    logic [3:0]  col_out, col_out_n;
    logic [1:0]  row_idx, row_idx_n;
    logic        frame_done, frame_done_n;
    logic [1:0]  dbg_state, dbg_state_n;

    int checks = 0;
    int errors = 0;
    int fd_cnt = 0;

    // Reference model: scan time since enable, plus display/pending contents.
    bit          m_scan = 1'b0;
    int          m_t = 0;
    logic [11:0] m_disp = '0;
    logic [11:0] m_pend = '0;
    bit          m_pv = 1'b0;
    bit          m_fd = 1'b0;

    led_matrix_scanner #(
        .ROWS(ROWS), .COLS(COLS), .DIV(DIV), .BLANK(BLANK),
        .ROW_ACTIVE_LOW(1'b0), .COL_ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .frame_in(frame_in),
        .row_sel(row_sel), .col_out(col_out), .row_idx(row_idx),
        .frame_done(frame_done), .dbg_state(dbg_state)
    );

    led_matrix_scanner #(
        .ROWS(ROWS), .COLS(COLS), .DIV(DIV), .BLANK(BLANK),
        .ROW_ACTIVE_LOW(1'b1), .COL_ACTIVE_LOW(1'b1)
    ) dut_n (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .frame_in(frame_in),
        .row_sel(row_sel_n), .col_out(col_out_n), .row_idx(row_idx_n),
        .frame_done(frame_done_n), .dbg_state(dbg_state_n)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_scan = 1'b0;
        m_t    = 0;
        m_disp = '0;
        m_pend = '0;
        m_pv   = 1'b0;
        m_fd   = 1'b0;
    endtask

    task automatic model_edge(input bit e, input bit ld, input logic [11:0] f);
        bit idle_old;
        bit bnd;
        idle_old = !m_scan;
        bnd = m_scan && e && (m_t == FRAME - 1);
        if (ld) begin
            m_pend = f;
            m_pv   = 1'b1;
        end
        if (bnd) begin
            if (ld) begin
                m_disp = f;
                m_pv   = 1'b0;
            end else if (m_pv) begin
                m_disp = m_pend;
                m_pv   = 1'b0;
            end
        end else if (idle_old && ld) begin
            m_disp = f;
        end
        m_fd = bnd;
        if (!e) begin
            m_scan = 1'b0;
            m_t    = 0;
        end else if (!m_scan) begin
            m_scan = 1'b1;
            m_t    = 0;
        end else begin
            m_t = (m_t + 1) % FRAME;
        end
    endtask

    task automatic check_all();
        logic [2:0] rs, rsn;
        logic [3:0] co, con;
        logic [1:0] ri;
        int row;
        rs = '0;
        co = '0;
        ri = '0;
        if (m_scan) begin
            row = m_t / PER;
            ri  = 2'(row);
            if ((m_t % PER) >= BLANK) begin
                rs = 3'(1 << row);
                co = 4'((m_disp >> (row * COLS)) & 12'hF);
            end
        end
        rsn = ~rs;
        con = ~co;
        chk("row_sel", row_sel, rs);
        chk("col_out", col_out, co);
        chk("row_idx", row_idx, ri);
        chk("frame_done", frame_done, m_fd);
        chk("row_sel_n", row_sel_n, rsn);
        chk("col_out_n", col_out_n, con);
        chk("row_idx_n", row_idx_n, ri);
        chk("frame_done_n", frame_done_n, m_fd);
    endtask

    task automatic cyc(input bit e, input bit ld, input logic [11:0] f);
        en       = e;
        load     = ld;
        frame_in = f;
        @(posedge clk);
        model_edge(e, ld, f);
        #1;
        check_all();
        if (frame_done) fd_cnt++;
    endtask

    initial begin
        // Reset and idle
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("dbg_idle", dbg_state, 2'd0);
        rst_n = 1'b1;
        cyc(0, 0, 12'h000);
        cyc(0, 0, 12'h000);

        // Basic scan of 12'hA5C loaded while idle
        cyc(0, 1, 12'hA5C);
        fd_cnt = 0;
        cyc(1, 0, 12'h000);
        cyc(1, 0, 12'h000);
        chk("basic_r0_sel", row_sel, 3'b001);
        chk("basic_r0_col", col_out, 4'hC);
        repeat (5) cyc(1, 0, 12'h000);
        chk("basic_r1_sel", row_sel, 3'b010);
        chk("basic_r1_col", col_out, 4'h5);
        repeat (5) cyc(1, 0, 12'h000);
        chk("basic_r2_sel", row_sel, 3'b100);
        chk("basic_r2_col", col_out, 4'hA);
        repeat (34) cyc(1, 0, 12'h000);
        chk("frame_done_count", fd_cnt, 3);

        // Double buffering: FFF loaded mid-frame while 000 is displayed
        cyc(1, 1, 12'h000);
        repeat (14) cyc(1, 0, 12'h000);
        repeat (3) cyc(1, 0, 12'h000);
        cyc(1, 1, 12'hFFF);
        repeat (2) cyc(1, 0, 12'h000);
        chk("dbuf_mid_col", col_out, 4'h0);
        repeat (9) cyc(1, 0, 12'h000);
        cyc(1, 0, 12'h000);
        chk("dbuf_next_col", col_out, 4'hF);

        // Load on the boundary edge overrides an older pending frame
        cyc(1, 1, 12'h111);
        repeat (12) cyc(1, 0, 12'h000);
        cyc(1, 1, 12'h222);
        cyc(1, 0, 12'h000);
        chk("simul_r0", col_out, 4'h2);
        repeat (5) cyc(1, 0, 12'h000);
        chk("simul_r1", col_out, 4'h2);
        repeat (5) cyc(1, 0, 12'h000);
        chk("simul_r2", col_out, 4'h2);
        repeat (5) cyc(1, 0, 12'h000);
        chk("simul_pv_clear", col_out, 4'h2);

        // Enable drop during row 1
        repeat (5) cyc(1, 0, 12'h000);
        cyc(0, 0, 12'h000);
        chk("endrop_sel", row_sel, 3'b000);
        chk("endrop_idx", row_idx, 2'd0);
        cyc(1, 0, 12'h000);
        chk("reen_blank", row_sel, 3'b000);
        cyc(1, 0, 12'h000);
        chk("reen_r0", row_sel, 3'b001);

        // Polarity on the active-low instance
        cyc(0, 0, 12'h000);
        cyc(0, 1, 12'h00F);
        cyc(1, 0, 12'h000);
        chk("pol_blank_sel", row_sel_n, 3'b111);
        chk("pol_blank_col", col_out_n, 4'b1111);
        cyc(1, 0, 12'h000);
        chk("pol_r0_sel", row_sel_n, 3'b110);
        chk("pol_r0_col", col_out_n, 4'b0000);

        // Asynchronous reset in the middle of a lit row
        cyc(1, 0, 12'h000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_sel", row_sel, 3'b000);
        chk("rst_col", col_out, 4'h0);
        chk("rst_fd", frame_done, 1'b0);
        chk("rst_idx", row_idx, 2'd0);
        chk("rst_sel_n", row_sel_n, 3'b111);
        chk("rst_col_n", col_out_n, 4'hF);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(0, 0, 12'h000);

        // Randomised traffic against the model
        for (int i = 0; i < 800; i++) begin
            cyc($urandom_range(0, 19) != 0, $urandom_range(0, 7) == 0, 12'($urandom_range(0, 4095)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
